// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and cycle sequencer for the 8-bit asynchronous
// external SRAM. Port 0 (core) has fixed priority over port 1 (DMA/loader),
// with a starvation guard that hands port 1 the bus after STARVE_MAX
// consecutive contested port-0 grants. Every pad-facing signal is registered.

module sram_arbiter #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [20:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [20:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,

    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_dq_i,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Down-counter start value: STROBE lasts WAIT_STATES cycles ending at zero.
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  starve_r, starve_s;
    logic        sel_r, sel_s;          // granted port: 0 = port 0, 1 = port 1
    logic        we_r, we_s;            // latched direction of the granted access

    logic        gnt_valid_s;
    logic        gnt_p1_s;

    logic [20:0] sram_addr_r, sram_addr_s;
    logic [7:0]  dq_o_r, dq_o_s;
    logic        dq_oe_r, dq_oe_s;
    logic        we_n_r, we_n_s;
    logic        ack0_r, ack0_s;
    logic        ack1_r, ack1_s;
    logic [7:0]  rdata0_r, rdata0_s;
    logic [7:0]  rdata1_r, rdata1_s;
    logic        busy_r, busy_s;

    // Arbitration: port 0 wins contested requests until the starvation limit.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_p1_s    = 1'b0;
        if (p0_req && p1_req) begin
            gnt_valid_s = 1'b1;
            gnt_p1_s    = (starve_r == STARVE_LIM);
        end else if (p0_req) begin
            gnt_valid_s = 1'b1;
            gnt_p1_s    = 1'b0;
        end else if (p1_req) begin
            gnt_valid_s = 1'b1;
            gnt_p1_s    = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_p1_s    = 1'b0;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        starve_s    = starve_r;
        sel_s       = sel_r;
        we_s        = we_r;
        sram_addr_s = sram_addr_r;
        dq_o_s      = dq_o_r;
        dq_oe_s     = dq_oe_r;
        we_n_s      = 1'b1;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        rdata0_s    = rdata0_r;
        rdata1_s    = rdata1_r;

        case (state_r)
            ST_IDLE: begin
                dq_oe_s = 1'b0;
                if (gnt_valid_s) begin
                    state_s = ST_ADDR;
                    sel_s   = gnt_p1_s;
                    if (gnt_p1_s) begin
                        we_s        = p1_we;
                        sram_addr_s = p1_addr;
                        if (p1_we) begin
                            dq_o_s = p1_wdata;
                        end else begin
                            dq_o_s = dq_o_r;
                        end
                        // Write drive starts with the address phase.
                        dq_oe_s  = p1_we;
                        starve_s = 4'd0;
                    end else begin
                        we_s        = p0_we;
                        sram_addr_s = p0_addr;
                        if (p0_we) begin
                            dq_o_s = p0_wdata;
                        end else begin
                            dq_o_s = dq_o_r;
                        end
                        dq_oe_s = p0_we;
                        // Count only port-0 grants that made port 1 wait.
                        if (p1_req) begin
                            starve_s = starve_r + 4'd1;
                        end else begin
                            starve_s = 4'd0;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                state_s = ST_STROBE;
                cnt_s   = WAIT_LOAD;
                we_n_s  = ~we_r;
            end

            ST_STROBE: begin
                if (cnt_r == 4'd0) begin
                    // Last strobe cycle ends here: release strobe, sample read data.
                    state_s = ST_DONE;
                    we_n_s  = 1'b1;
                    if (sel_r) begin
                        ack1_s = 1'b1;
                        if (!we_r) begin
                            rdata1_s = sram_dq_i;
                        end else begin
                            rdata1_s = rdata1_r;
                        end
                    end else begin
                        ack0_s = 1'b1;
                        if (!we_r) begin
                            rdata0_s = sram_dq_i;
                        end else begin
                            rdata0_s = rdata0_r;
                        end
                    end
                end else begin
                    cnt_s  = cnt_r - 4'd1;
                    we_n_s = ~we_r;
                end
            end

            ST_DONE: begin
                // Data hold cycle is over; release the pad on the way to IDLE.
                state_s = ST_IDLE;
                dq_oe_s = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                dq_oe_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // Sequencer state and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            starve_r <= 4'd0;
            sel_r    <= 1'b0;
            we_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            starve_r <= starve_s;
            sel_r    <= sel_s;
            we_r     <= we_s;
            busy_r   <= busy_s;
        end
    end

    // Pad-side and requester-side output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr_r <= 21'd0;
            dq_o_r      <= 8'h00;
            dq_oe_r     <= 1'b0;
            we_n_r      <= 1'b1;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata0_r    <= 8'h00;
            rdata1_r    <= 8'h00;
        end else begin
            sram_addr_r <= sram_addr_s;
            dq_o_r      <= dq_o_s;
            dq_oe_r     <= dq_oe_s;
            we_n_r      <= we_n_s;
            ack0_r      <= ack0_s;
            ack1_r      <= ack1_s;
            rdata0_r    <= rdata0_s;
            rdata1_r    <= rdata1_s;
        end
    end

    assign sram_addr  = sram_addr_r;
    assign sram_dq_o  = dq_o_r;
    assign sram_dq_oe = dq_oe_r;
    assign sram_we_n  = we_n_r;
    assign p0_ack     = ack0_r;
    assign p1_ack     = ack1_r;
    assign p0_rdata   = rdata0_r;
    assign p1_rdata   = rdata1_r;
    assign busy       = busy_r;

    sram_arbiter_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .p0_ack     (ack0_r),
        .p1_ack     (ack1_r),
        .sram_we_n  (we_n_r),
        .sram_dq_oe (dq_oe_r),
        .busy       (busy_r)
    );

endmodule

// Safety properties on the pad and handshake outputs.
module sram_arbiter_chk (
    input  logic clk,
    input  logic rst,
    input  logic p0_ack,
    input  logic p1_ack,
    input  logic sram_we_n,
    input  logic sram_dq_oe,
    input  logic busy
);

    // Only one port is ever acknowledged in a cycle.
    a_one_ack: assert property (@(posedge clk) disable iff (rst) !(p0_ack && p1_ack));

    // A write strobe is only ever issued while the data bus is being driven.
    a_strobe_oe: assert property (@(posedge clk) disable iff (rst) !sram_we_n |-> sram_dq_oe);

    // The pad is never driven while the sequencer is idle.
    a_idle_oe: assert property (@(posedge clk) disable iff (rst) !busy |-> !sram_dq_oe);

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed vectors with a scoreboard. Stimulus
// pushes the expected completion (port, both rdata values, write data on the
// pad) into a queue; a monitor pops and compares on every ack.

module tb_sram_arbiter;

    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we;
    logic [20:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p0_ack;
    logic [7:0]  p0_rdata;
    logic        p1_req, p1_we;
    logic [20:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        p1_ack;
    logic [7:0]  p1_rdata;
    logic [20:0] sram_addr;
    logic [7:0]  dq_drive;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        busy;

    typedef struct {
        int         port;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic       chk_dq;
        logic [7:0] dq;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         ack_count = 0;
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;

    sram_arbiter #(
        .WAIT_STATES (WS),
        .STARVE_MAX  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_ack     (p0_ack),
        .p0_rdata   (p0_rdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_ack     (p1_ack),
        .p1_rdata   (p1_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_i  (dq_drive),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops the next expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (p0_ack || p1_ack)) begin
            ack_count++;
            check("dual_ack", 32'(p0_ack && p1_ack), 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(sb.size()), 32'h1);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(p1_ack), 32'(e.port));
                check("p0_rdata", 32'(p0_rdata), 32'(e.rd0));
                check("p1_rdata", 32'(p1_rdata), 32'(e.rd1));
                if (e.chk_dq) begin
                    check("ack_dq_o", 32'(sram_dq_o), 32'(e.dq));
                end
            end
        end
    end

    task automatic push_exp(input int port, input logic we, input logic [7:0] wd);
        exp_t e;
        e.port   = port;
        e.rd0    = exp_rd0;
        e.rd1    = exp_rd1;
        e.chk_dq = we;
        e.dq     = wd;
        sb.push_back(e);
    endtask

    // One isolated access with cycle-by-cycle pad checks; starts and ends idle.
    task automatic single(input int port, input logic we, input logic [20:0] addr,
                          input logic [7:0] wd, input logic [7:0] dq);
        dq_drive = dq;
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
            if (!we) exp_rd0 = dq;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
            if (!we) exp_rd1 = dq;
        end
        push_exp(port, we, wd);
        for (int c = 0; c <= WS + 3; c++) begin
            @(negedge clk);
            check("we_n", 32'(sram_we_n), 32'(!(we && c >= 2 && c <= WS + 1)));
            check("dq_oe", 32'(sram_dq_oe), 32'(we && c >= 1 && c <= WS + 2));
            check("busy", 32'(busy), 32'(c >= 1 && c <= WS + 2));
            check("own_ack", 32'(port == 0 ? p0_ack : p1_ack), 32'(c == WS + 2));
            check("other_ack", 32'(port == 0 ? p1_ack : p0_ack), 32'h0);
            if (c >= 1) begin
                check("sram_addr", 32'(sram_addr), 32'(addr));
                if (we) check("dq_o", 32'(sram_dq_o), 32'(wd));
            end
            tick();
            if (c == WS + 2) begin
                if (port == 0) p0_req = 1'b0;
                else p1_req = 1'b0;
            end
        end
    endtask

    initial begin
        bit done;
        int target;

        // Reset held 3 cycles with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p0_req = 1'($urandom_range(0, 1)); p0_we = 1'($urandom_range(0, 1));
            p0_addr = 21'($urandom); p0_wdata = 8'($urandom);
            p1_req = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
            p1_addr = 21'($urandom); p1_wdata = 8'($urandom);
            dq_drive = 8'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_o", 32'(sram_dq_o), 32'h0);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_ack", 32'({p0_ack, p1_ack}), 32'h0);
        check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // Port-0 read and port-1 write at the address boundary.
        single(0, 1'b0, 21'h00123, 8'h00, 8'hA5);
        single(1, 1'b1, 21'h1FFFFF, 8'h3C, 8'h00);

        // Simultaneous requests: port 0 first, port 1 five cycles later.
        p0_we = 1'b0; p0_addr = 21'h00456;
        p1_we = 1'b0; p1_addr = 21'h00789;
        exp_rd0 = 8'hC3; push_exp(0, 1'b0, 8'h00);
        exp_rd1 = 8'h5A; push_exp(1, 1'b0, 8'h00);
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin dq_drive = 8'hC3; p0_req = 1'b1; p1_req = 1'b1; end
            if (c == 5) begin p0_req = 1'b0; dq_drive = 8'h5A; end
            if (c == 10) p1_req = 1'b0;
            @(negedge clk);
            check("sim_p0_ack", 32'(p0_ack), 32'(c == 4));
            check("sim_p1_ack", 32'(p1_ack), 32'(c == 9));
            if (c == 6) check("sim_p1_addr", 32'(sram_addr), 32'h00789);
            tick();
        end

        // Starvation guard: both held, order p0 x4, p1, p0 x4, p1.
        p0_we = 1'b1; p0_addr = 21'h00AAA; p0_wdata = 8'h11;
        p1_we = 1'b1; p1_addr = 21'h1ABCD; p1_wdata = 8'h22;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) push_exp(1, 1'b1, 8'h22);
            else push_exp(0, 1'b1, 8'h11);
        end
        target = ack_count + 10;
        done = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (ack_count >= target) done = 1'b1;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("starve_timeout", 32'(done), 32'h1);
        tick();
        tick();

        // Reset during the first strobe cycle of a write.
        p0_we = 1'b1; p0_addr = 21'h00055; p0_wdata = 8'h99; p0_req = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("mid_oe_addr", 32'(sram_dq_oe), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_strobe", 32'(sram_we_n), 32'h0);
        tick();
        rst = 1'b0; p0_req = 1'b0;
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        @(negedge clk);
        check("mid_we_n", 32'(sram_we_n), 32'h1);
        check("mid_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_ack", 32'({p0_ack, p1_ack}), 32'h0);
        check("mid_rdata", 32'({p0_rdata, p1_rdata}), 32'h0);
        for (int i = 0; i < 6; i++) tick();

        // Normal traffic after the abort.
        single(1, 1'b0, 21'h0ABCD, 8'h00, 8'h7E);
        single(0, 1'b1, 21'h00001, 8'hE7, 8'h00);

        tick();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
